// File: rtl/vx_flush_unit_pkg.sv
// -----------------------------------------------------------------------------
// vx_flush_unit_pkg
// Shared definitions for the cache flush sequencer: flush FSM state encoding
// and helpers that derive geometry (lines per bank, index widths) from the
// cache parameters. No ports; imported by vx_flush_unit and its sub-module.
// -----------------------------------------------------------------------------
package vx_flush_unit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } flush_state_t;

   // Lines held by a single way of a single bank.
   function automatic int lines_per_bank(input int cache_size, input int line_size,
                                         input int num_banks, input int num_ways);
      return cache_size / (line_size * num_banks * num_ways);
   endfunction

   // Index width for a count of n entries; never narrower than one bit so that
   // degenerate (single entry) counters still have a legal vector type.
   function automatic int sel_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Line-select width of the whole cache (all banks/ways folded together).
   function automatic int line_select_bits(input int cache_size, input int line_size);
      return sel_bits(cache_size / line_size);
   endfunction

endpackage

// File: rtl/vx_flush_lockstep.sv
// -----------------------------------------------------------------------------
// vx_flush_lockstep
// Keeps every bank on the same (line, way) beat. Each bank's beat is offered
// until that bank accepts it; a bank that has accepted sees valid low until all
// banks have accepted, at which point beat_done pulses and the mask clears.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   enable       beats are being offered (FSM in FLUSH)
//   ready_in     per-bank accept
//   valid_out    per-bank beat valid (~sent while enabled)
//   beat_done    every bank has taken the current beat (this cycle included)
// -----------------------------------------------------------------------------
module vx_flush_lockstep #(
   parameter int NUM_BANKS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NUM_BANKS-1:0] ready_in,
   output logic [NUM_BANKS-1:0] valid_out,
   output logic                 beat_done
);

   logic [NUM_BANKS-1:0] sent;
   logic [NUM_BANKS-1:0] fire;

   assign valid_out = enable ? ~sent : '0;
   assign fire      = valid_out & ready_in;
   // Banks that fire this cycle count as done for the beat, so a beat where
   // every bank is ready completes in a single cycle.
   assign beat_done = enable && ((sent | fire) == {NUM_BANKS{1'b1}});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sent <= '0;
      end else if (!enable || beat_done) begin
         sent <= '0;
      end else begin
         sent <= sent | fire;
      end
   end

endmodule

// File: rtl/vx_flush_unit.sv
// -----------------------------------------------------------------------------
// vx_flush_unit
// Walks every (line, way) of every bank issuing one invalidation beat per
// bank, after reset (FLUSH_ON_RESET=1) and on demand. Way is the inner loop.
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the clock edge; valid never depends combinationally on ready.
//   flush request : flush_req_valid/flush_req_ready, ready only in IDLE.
//   bank beat     : valid_out[b]/ready_in[b], addr_out/way_out held stable
//                   while any valid_out bit is high.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   flush_req_valid   on-demand flush request
//   flush_req_ready   request accepted when valid&ready
//   flush_done        one-cycle pulse when a flush completes
//   busy              flush in progress
//   valid_out/ready_in per-bank beat handshake
//   addr_out/way_out  line and way index shared by all banks
//   dbg_state         current FSM state, for observation only
// -----------------------------------------------------------------------------
module vx_flush_unit
   import vx_flush_unit_pkg::*;
#(
   parameter int CACHE_SIZE      = 16384,
   parameter int CACHE_LINE_SIZE = 64,
   parameter int NUM_BANKS       = 1,
   parameter int NUM_WAYS        = 1,
   parameter int FLUSH_ON_RESET  = 1,
   localparam int LINES_PER_BANK = lines_per_bank(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS, NUM_WAYS),
   localparam int LINE_SEL_BITS  = sel_bits(LINES_PER_BANK),
   localparam int WAY_SEL_BITS   = sel_bits(NUM_WAYS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_req_valid,
   output logic                     flush_req_ready,
   output logic                     flush_done,
   output logic                     busy,
   output logic [NUM_BANKS-1:0]     valid_out,
   input  logic [NUM_BANKS-1:0]     ready_in,
   output logic [LINE_SEL_BITS-1:0] addr_out,
   output logic [WAY_SEL_BITS-1:0]  way_out,
   output flush_state_t             dbg_state
);

   // Explicit terminal values: counts need not be powers of two, so the
   // counters are reloaded on compare rather than left to wrap.
   localparam logic [LINE_SEL_BITS-1:0] LAST_LINE = LINE_SEL_BITS'(LINES_PER_BANK - 1);
   localparam logic [WAY_SEL_BITS-1:0]  LAST_WAY  = WAY_SEL_BITS'(NUM_WAYS - 1);

   flush_state_t             state;
   logic [LINE_SEL_BITS-1:0] line;
   logic [WAY_SEL_BITS-1:0]  way;
   logic                     beat_done;

   vx_flush_lockstep #(
      .NUM_BANKS (NUM_BANKS)
   ) u_lockstep (
      .clk       (clk),
      .reset     (reset),
      .enable    (state == FLUSH),
      .ready_in  (ready_in),
      .valid_out (valid_out),
      .beat_done (beat_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= (FLUSH_ON_RESET != 0) ? FLUSH : IDLE;
         line       <= '0;
         way        <= '0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         case (state)
            IDLE: begin
               if (flush_req_valid) begin
                  state <= FLUSH;
                  line  <= '0;
                  way   <= '0;
               end
            end
            FLUSH: begin
               if (beat_done) begin
                  if (way == LAST_WAY) begin
                     way <= '0;
                     if (line == LAST_LINE) begin
                        line       <= '0;
                        state      <= DONE;
                        flush_done <= 1'b1;
                     end else begin
                        line <= line + LINE_SEL_BITS'(1);
                     end
                  end else begin
                     way <= way + WAY_SEL_BITS'(1);
                  end
               end
            end
            DONE: begin
               // Requests are not taken here; a held request is seen in IDLE.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign flush_req_ready = (state == IDLE);
   assign busy            = (state == FLUSH);
   assign addr_out        = line;
   assign way_out         = way;
   assign dbg_state       = state;

endmodule

// File: tb/tb_vx_flush_unit.sv
// -----------------------------------------------------------------------------
// tb_vx_flush_unit
// Three instances: A (1024B/16B, 2 banks, 2 ways, flush on reset),
// B (same geometry, no flush on reset), C (768B/16B, 1 bank, 3 ways).
// A beat-index model predicts every output each cycle; per-bank beat counters
// and an expected queue check the (addr, way) sequence each bank receives.
// -----------------------------------------------------------------------------
module tb_vx_flush_unit;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT wiring ----------------
   logic       req [3];
   logic [1:0] rdy [3];

   logic       a_ready, a_done, a_busy;
   logic [1:0] a_valid;
   logic [3:0] a_addr;
   logic [0:0] a_way;
   logic [1:0] a_dbg;
   logic       b_ready, b_done, b_busy;
   logic [1:0] b_valid;
   logic [3:0] b_addr;
   logic [0:0] b_way;
   logic [1:0] b_dbg;
   logic       c_ready, c_done, c_busy;
   logic [0:0] c_valid;
   logic [3:0] c_addr;
   logic [1:0] c_way;
   logic [1:0] c_dbg;

   vx_flush_unit #(.CACHE_SIZE(1024), .CACHE_LINE_SIZE(16), .NUM_BANKS(2), .NUM_WAYS(2),
                   .FLUSH_ON_RESET(1)) dut_a (
      .clk(clk), .reset(rst), .flush_req_valid(req[0]), .flush_req_ready(a_ready),
      .flush_done(a_done), .busy(a_busy), .valid_out(a_valid), .ready_in(rdy[0]),
      .addr_out(a_addr), .way_out(a_way), .dbg_state(a_dbg));

   vx_flush_unit #(.CACHE_SIZE(1024), .CACHE_LINE_SIZE(16), .NUM_BANKS(2), .NUM_WAYS(2),
                   .FLUSH_ON_RESET(0)) dut_b (
      .clk(clk), .reset(rst), .flush_req_valid(req[1]), .flush_req_ready(b_ready),
      .flush_done(b_done), .busy(b_busy), .valid_out(b_valid), .ready_in(rdy[1]),
      .addr_out(b_addr), .way_out(b_way), .dbg_state(b_dbg));

   vx_flush_unit #(.CACHE_SIZE(768), .CACHE_LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(3),
                   .FLUSH_ON_RESET(1)) dut_c (
      .clk(clk), .reset(rst), .flush_req_valid(req[2]), .flush_req_ready(c_ready),
      .flush_done(c_done), .busy(c_busy), .valid_out(c_valid), .ready_in(rdy[2][0:0]),
      .addr_out(c_addr), .way_out(c_way), .dbg_state(c_dbg));

   // Uniform views of the three instances.
   logic        o_ready [3], o_done [3], o_busy [3];
   logic [1:0]  o_valid [3];
   logic [31:0] o_addr [3], o_way [3];
   assign o_ready[0] = a_ready;  assign o_ready[1] = b_ready;  assign o_ready[2] = c_ready;
   assign o_done[0]  = a_done;   assign o_done[1]  = b_done;   assign o_done[2]  = c_done;
   assign o_busy[0]  = a_busy;   assign o_busy[1]  = b_busy;   assign o_busy[2]  = c_busy;
   assign o_valid[0] = a_valid;  assign o_valid[1] = b_valid;  assign o_valid[2] = {1'b0, c_valid};
   assign o_addr[0]  = {28'd0, a_addr};
   assign o_addr[1]  = {28'd0, b_addr};
   assign o_addr[2]  = {28'd0, c_addr};
   assign o_way[0]   = {31'd0, a_way};
   assign o_way[1]   = {31'd0, b_way};
   assign o_way[2]   = {30'd0, c_way};

   // Geometry of each instance from the cache parameters.
   int nb    [3] = '{2, 2, 1};
   int nw    [3] = '{2, 2, 3};
   int tot   [3] = '{32, 32, 48};   // lines per bank * ways
   int for_r [3] = '{1, 0, 1};

   // ---------------- scoreboard ----------------
   int compared   = 0;
   int mismatched = 0;

   function automatic void chk(input string name, input int d,
                               input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, d, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 flushing, 2 done.  k: index of the beat being offered.
   int         m_mode [3];
   int         m_k    [3];
   logic [1:0] m_sent [3];
   int         bcnt   [3][2];        // beats each bank has actually taken
   logic [7:0] exp_q[$];             // instance C: {addr, way} keys still owed

   function automatic logic [1:0] allm(input int d);
      return (nb[d] == 2) ? 2'b11 : 2'b01;
   endfunction

   function automatic logic [1:0] m_valid(input int d);
      return (m_mode[d] == 1) ? (~m_sent[d] & allm(d)) : 2'b00;
   endfunction

   function automatic void start_flush(input int d);
      bcnt[d][0] = 0;
      bcnt[d][1] = 0;
      if (d == 2) begin
         exp_q.delete();
         for (int k = 0; k < tot[2]; k++) exp_q.push_back(8'((k / nw[2]) * 16 + (k % nw[2])));
      end
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_mode[d] = (for_r[d] != 0) ? 1 : 0;
            m_k[d]    = 0;
            m_sent[d] = 2'b00;
            start_flush(d);
         end else begin
            case (m_mode[d])
               0: if (req[d]) begin
                     m_mode[d] = 1;
                     m_k[d]    = 0;
                     m_sent[d] = 2'b00;
                     start_flush(d);
                  end
               1: begin
                     logic [1:0] f;
                     f = m_valid(d) & rdy[d];
                     if (((m_sent[d] | f) & allm(d)) == allm(d)) begin
                        m_sent[d] = 2'b00;
                        m_k[d]++;
                        if (m_k[d] == tot[d]) begin
                           m_mode[d] = 2;
                           m_k[d]    = 0;
                        end
                     end else begin
                        m_sent[d] = m_sent[d] | f;
                     end
                  end
               default: m_mode[d] = 0;
            endcase
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         chk("busy",  d, {31'd0, o_busy[d]},  {31'd0, m_mode[d] == 1});
         chk("ready", d, {31'd0, o_ready[d]}, {31'd0, m_mode[d] == 0});
         chk("done",  d, {31'd0, o_done[d]},  {31'd0, m_mode[d] == 2});
         chk("valid", d, {30'd0, o_valid[d]}, {30'd0, m_valid(d)});
         chk("addr",  d, o_addr[d], (m_mode[d] == 1) ? m_k[d] / nw[d] : 0);
         chk("way",   d, o_way[d],  (m_mode[d] == 1) ? m_k[d] % nw[d] : 0);
         if (m_mode[d] == 2) begin
            for (int b = 0; b < nb[d]; b++) chk("beats_per_bank", d, bcnt[d][b], tot[d]);
            if (d == 2) chk("exp_q_drained", d, exp_q.size(), 0);
         end
      end
   end

   // Beat monitor: after inputs settle, record every bank that will fire at
   // the coming edge and check it is the next beat that bank is owed.
   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         for (int d = 0; d < 3; d++) begin
            for (int b = 0; b < nb[d]; b++) begin
               if (o_valid[d][b] && rdy[d][b]) begin
                  chk("beat_addr", d, o_addr[d], bcnt[d][b] / nw[d]);
                  chk("beat_way",  d, o_way[d],  bcnt[d][b] % nw[d]);
                  bcnt[d][b]++;
                  if (d == 2) begin
                     if (exp_q.size() == 0) chk("exp_q_underflow", d, 1, 0);
                     else chk("beat_key", d, 32'(o_addr[d] * 16 + o_way[d]), {24'd0, exp_q.pop_front()});
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int a_at, c_at, first, dn, ok;

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         req[d] = 1'b0;
         rdy[d] = 2'b11;
      end
      repeat (2) @(negedge clk);

      // Reset state, hand-computed.
      chk("rst_a_busy",  0, {31'd0, o_busy[0]},  1);
      chk("rst_a_valid", 0, {30'd0, o_valid[0]}, 3);
      chk("rst_a_addr",  0, o_addr[0], 0);
      chk("rst_b_busy",  1, {31'd0, o_busy[1]},  0);
      chk("rst_b_valid", 1, {30'd0, o_valid[1]}, 0);
      chk("rst_b_ready", 1, {31'd0, o_ready[1]}, 1);
      chk("rst_c_valid", 2, {30'd0, o_valid[2]}, 1);
      chk("rst_done",    0, {31'd0, o_done[0]},  0);
      #1 rst = 1'b0;

      // Flush on reset with all banks ready; on-demand request into B.
      a_at = 0;
      c_at = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (o_done[0] && a_at == 0) a_at = cyc;
         if (o_done[2] && c_at == 0) c_at = cyc;
         if (cyc == 31) begin
            chk("a_last_addr", 0, o_addr[0], 15);
            chk("a_last_way",  0, o_way[0],  1);
         end
         if (cyc == 32) chk("a_busy_at_done", 0, {31'd0, o_busy[0]}, 0);
         if (cyc == 5) begin
            chk("b_req_ready", 1, {31'd0, o_ready[1]}, 1);
            #1 req[1] = 1'b1;
         end
         if (cyc == 6) begin
            chk("b_valid_t1", 1, {30'd0, o_valid[1]}, 3);
            chk("b_addr_t1",  1, o_addr[1], 0);
            #1 req[1] = 1'b0;
         end
      end
      chk("a_done_cycle", 0, a_at, 32);
      chk("c_done_cycle", 2, c_at, 48);

      // Bank 1 of A stalls for three cycles on beat 3 = (1,1).
      #1 req[0] = 1'b1;
      @(negedge clk);
      #1 req[0] = 1'b0;
      first = 0;
      for (int e = 1; e <= 40; e++) begin
         rdy[0] = (e >= 4 && e <= 6) ? 2'b01 : 2'b11;
         @(negedge clk);
         if (o_done[0] && first == 0) first = e;
         if (e >= 4 && e <= 6) begin
            chk("stall_valid", 0, {30'd0, o_valid[0]}, 2);
            chk("stall_addr",  0, o_addr[0], 1);
            chk("stall_way",   0, o_way[0],  1);
         end
         if (e == 7) begin
            chk("resume_valid", 0, {30'd0, o_valid[0]}, 3);
            chk("resume_addr",  0, o_addr[0], 2);
            chk("resume_way",   0, o_way[0],  0);
         end
         #1;
      end
      chk("stall_done_cycle", 0, first, 35);

      // Request held high: ignored while busy and in DONE, retaken in IDLE.
      dn = 0;
      for (int e = 1; e <= 80; e++) begin
         req[0] = 1'b1;
         @(negedge clk);
         if (o_done[0]) begin
            dn++;
            chk("held_ready_in_done", 0, {31'd0, o_ready[0]}, 0);
         end
         #1;
      end
      req[0] = 1'b0;
      chk("held_done_count", 0, dn, 2);

      // Random requests and per-bank backpressure.
      for (int e = 0; e < 600; e++) begin
         for (int d = 0; d < 3; d++) begin
            req[d] = ($urandom_range(0, 3) == 0);
            rdy[d] = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
         #1;
      end

      // Asynchronous reset in the middle of a flush at (7,1).
      for (int d = 0; d < 3; d++) begin
         req[d] = 1'b0;
         rdy[d] = 2'b11;
      end
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (o_ready[0] === 1'b1) begin
            ok = 1;
            break;
         end
      end
      chk("idle_wait", 0, ok, 1);
      #1 req[0] = 1'b1;
      @(negedge clk);
      #1 req[0] = 1'b0;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (m_mode[0] == 1 && m_k[0] == 15) begin
            ok = 1;
            break;
         end
      end
      chk("reach_7_1", 0, ok, 1);
      chk("pre_rst_addr", 0, o_addr[0], 7);
      chk("pre_rst_way",  0, o_way[0],  1);
      #3 rst = 1'b1;
      #1;
      chk("async_valid", 0, {30'd0, o_valid[0]}, 3);
      chk("async_busy",  0, {31'd0, o_busy[0]},  1);
      chk("async_addr",  0, o_addr[0], 0);
      chk("async_way",   0, o_way[0],  0);
      chk("async_done",  0, {31'd0, o_done[0]},  0);
      chk("async_b_busy", 1, {31'd0, o_busy[1]}, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      first = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (o_done[0] && first == 0) first = cyc;
      end
      chk("restart_done_cycle", 0, first, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
